mtrisc_prefetch: RTL and testbench

Instruction prefetch stage that sits directly upstream of the mtrisc core's instruction register. It fetches sequential 32-bit words from instruction memory through a request/grant/response port and buffers them in a small FIFO. It presents them to the core with a valid/ready handshake. A redirect from the core (taken branch or jump) flushes the buffer and restarts fetch at the new address, discarding any read already in flight.

---
 rtl/mtrisc_prefetch.sv | 130 +++++++++++++
 tb/tb_mtrisc_prefetch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtrisc_prefetch.sv
// mtrisc instruction prefetch: sequential fetch into a small FIFO,
// valid/ready toward the core, redirect flushes and restarts fetch.
module mtrisc_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rnt_p,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ins_ready,
  output logic        ins_valid,
  output logic [31:0] ins_data,
  output logic [31:0] ins_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   gnt_addr_q, gnt_addr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] room;
  logic          push;
  logic          pop;

  logic [31:0] dat_q [DEPTH];
  logic [31:0] pc_q  [DEPTH];

  assign ins_valid = (count_q != '0);
  assign ins_data  = ins_valid ? dat_q[rd_ptr_q] : 32'h0;
  assign ins_pc    = ins_valid ? pc_q[rd_ptr_q] : 32'h0;
  assign mem_req   = (state_q == S_REQ);
  assign mem_addr  = fetch_pc_q;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    gnt_addr_d = gnt_addr_q;
    push       = 1'b0;
    pop        = ins_valid & ins_ready & ~redirect;
    room       = count_q + CW'(1) - CW'(pop);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (count_q < DEPTH_C) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d    = S_WAIT;
          fetch_pc_d = fetch_pc_q + 32'd4;
          gnt_addr_d = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          push    = ~redirect;
          state_d = (room < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (mem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect abandons buffered words; an in-flight read turns stale.
    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      unique case (state_q)
        S_REQ:   state_d = mem_gnt ? S_DROP : S_REQ;
        S_WAIT:  state_d = mem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_d = S_DROP;
        default: state_d = S_REQ;
      endcase
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rnt_p) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      gnt_addr_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      gnt_addr_q <= gnt_addr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dat_q[wr_ptr_q] <= mem_rdata;
      pc_q[wr_ptr_q]  <= gnt_addr_q;
    end
  end

endmodule

// File: tb/tb_mtrisc_prefetch.sv
// Directed bench for mtrisc_prefetch with a simple
// request/grant/response memory model of programmable latency.
module tb_mtrisc_prefetch;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] XK  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rnt_p = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ins_ready = 1'b0;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        gnt_en = 1'b1;
  int          rdelay = 1;
  logic        inj_rv = 1'b0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;
  logic        mdl_rv;
  logic [31:0] gq [$];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mtrisc_prefetch #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .clk(clk),
    .rnt_p(rnt_p),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .ins_ready(ins_ready),
    .ins_valid(ins_valid),
    .ins_data(ins_data),
    .ins_pc(ins_pc),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  assign mem_gnt    = gnt_en & mem_req;
  assign mdl_rv     = pend && (cnt == 1);
  assign mem_rvalid = mdl_rv | inj_rv;
  assign mem_rdata  = inj_rv ? 32'hDEAD_BEEF :
                      (mdl_rv ? (paddr ^ XK) : 32'h0);

  always @(posedge clk) begin
    if (rnt_p) begin
      pend <= 1'b0;
    end else begin
      if (pend && cnt == 1) pend <= 1'b0;
      else if (pend) cnt <= cnt - 1;
      if (mem_req && mem_gnt) begin
        pend  <= 1'b1;
        cnt   <= rdelay;
        paddr <= mem_addr;
      end
    end
  end

  always @(posedge clk) begin
    if (mem_req && mem_gnt) gq.push_back(mem_addr);
  end

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] p2;
  } vec_t;

  vec_t vt [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rnt_p    = 1'b1;
    redirect = 1'b0;
    inj_rv   = 1'b0;
    tick();
    tick();
    chk("rst_valid", {31'b0, ins_valid}, 32'd0);
    chk("rst_data", ins_data, 32'h0);
    chk("rst_pc", ins_pc, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, RPC);
    rnt_p = 1'b0;
    gq.delete();
  endtask

  task automatic get_word(output logic [31:0] pc,
                          output logic [31:0] d,
                          output logic ok);
    ok = 1'b0;
    pc = 32'h0;
    d  = 32'h0;
    for (int i = 0; i < 60; i++) begin
      if (ins_valid && ins_ready) begin
        pc = ins_pc;
        d  = ins_data;
        ok = 1'b1;
        tick();
        return;
      end
      tick();
    end
  endtask

  task automatic expect_word(input string nm,
                             input logic [31:0] epc);
    logic [31:0] pc;
    logic [31:0] d;
    logic        ok;
    get_word(pc, d, ok);
    chk({nm, "_avail"}, {31'b0, ok}, 32'd1);
    chk({nm, "_pc"}, pc, epc);
    chk({nm, "_data"}, d, epc ^ XK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vt[0] = '{32'h0000_0102, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    vt[1] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    vt[2] = '{32'h0000_0043, 32'h0000_0040, 32'h0000_0044, 32'h0000_0048};
    vt[3] = '{32'h0000_1000, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008};

    // Streaming with a 1-cycle memory
    ins_ready = 1'b1;
    rdelay    = 1;
    do_reset();
    lat = 0;
    while (!ins_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("first_valid_lat", lat, 3);
    for (int i = 0; i < 6; i++)
      expect_word($sformatf("stream%0d", i), 32'(i * 4));

    // Backpressure fills exactly DEPTH entries
    ins_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 30; i++) tick();
    chk("full_grants", gq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("full_addr%0d", i),
          (gq.size() > i) ? gq[i] : 32'hX, 32'(i * 4));
    chk("full_noreq", {31'b0, mem_req}, 32'd0);
    gq.delete();
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("refill_grants", gq.size(), 1);
    chk("refill_addr", (gq.size() > 0) ? gq[0] : 32'hX, 32'd16);
    chk("refill_head", ins_pc, 32'd4);

    // Redirect while a slow read is in flight
    ins_ready = 1'b1;
    rdelay    = 3;
    do_reset();
    lat = 0;
    while (lat < 60 && !(gq.size() > 0 && gq[$] == 32'd8)) begin
      tick();
      lat++;
    end
    chk("grant8_seen", (lat < 60) ? 32'd1 : 32'd0, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    chk("drop_req0", {31'b0, mem_req}, 32'd0);
    chk("drop_valid0", {31'b0, ins_valid}, 32'd0);
    tick();
    chk("drop_req1", {31'b0, mem_req}, 32'd0);
    chk("drop_valid1", {31'b0, ins_valid}, 32'd0);
    rdelay = 1;
    tick();
    chk("drop_resume_req", {31'b0, mem_req}, 32'd1);
    chk("drop_resume_addr", mem_addr, 32'h0000_0100);
    expect_word("drop_first", 32'h0000_0100);

    // Redirect in the same cycle as a response and a pop
    ins_ready = 1'b0;
    lat = 0;
    while (lat < 40 && !(ins_valid && mem_rvalid)) begin
      tick();
      lat++;
    end
    chk("coinc_setup", (lat < 40) ? 32'd1 : 32'd0, 32'd1);
    ins_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    chk("coinc_valid", {31'b0, ins_valid}, 32'd0);
    chk("coinc_req", {31'b0, mem_req}, 32'd1);
    chk("coinc_addr", mem_addr, 32'h0000_0200);
    expect_word("coinc_first", 32'h0000_0200);

    // Table of redirect targets, taken from varying pipeline states
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < v + 2; k++) tick();
      redirect    = 1'b1;
      redirect_pc = vt[v].rpc;
      tick();
      redirect = 1'b0;
      chk($sformatf("tbl%0d_valid", v), {31'b0, ins_valid}, 32'd0);
      expect_word($sformatf("tbl%0d_w0", v), vt[v].p0);
      expect_word($sformatf("tbl%0d_w1", v), vt[v].p1);
      expect_word($sformatf("tbl%0d_w2", v), vt[v].p2);
    end

    // Reset in the middle of a read, stale responses after
    rdelay = 5;
    do_reset();
    lat = 0;
    while (lat < 20 && gq.size() == 0) begin
      tick();
      lat++;
    end
    chk("rstmid_grant", (lat < 20) ? 32'd1 : 32'd0, 32'd1);
    rnt_p = 1'b1;
    tick();
    inj_rv = 1'b1;
    tick();
    rnt_p = 1'b0;
    chk("rstmid_req0", {31'b0, mem_req}, 32'd0);
    chk("rstmid_valid0", {31'b0, ins_valid}, 32'd0);
    rdelay = 1;
    tick();
    inj_rv = 1'b0;
    chk("rstmid_req1", {31'b0, mem_req}, 32'd1);
    chk("rstmid_addr", mem_addr, RPC);
    chk("rstmid_valid1", {31'b0, ins_valid}, 32'd0);
    expect_word("rstmid_first", RPC);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
